// File: rtl/soc_system_audio_capture_ctrl.sv
// Audio capture controller: samples the stereo codec word on each strobe,
// buffers it in a circular FIFO and exposes data/status/control/threshold
// registers on an Avalon-MM slave with a level-threshold interrupt.
module soc_system_audio_capture_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_port,
  input  logic              sample_valid,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] THR_RST  = LVL_W'(DEPTH / 2);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_THR    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;
  logic [2:0]              ctrl_q, ctrl_d;
  logic [LVL_W-1:0]        thr_q, thr_d;
  logic [31:0]             readdata_q, readdata_d;
  logic                    irq_q, irq_d;
  logic [DATA_W-1:0]       mem_q [DEPTH];

  logic        fifo_empty;
  logic        fifo_full;
  logic        cs_rd;
  logic        cs_wr;
  logic        pop_req;
  logic        do_pop;
  logic        push_req;
  logic        push_drop;
  logic        do_push;
  logic        flush;
  logic [31:0] status_word;

  // Decode bus accesses and work out this cycle's FIFO push/pop/drop events
  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == FULL_LVL);
    cs_rd      = chipselect & read;
    cs_wr      = chipselect & write;
    pop_req    = cs_rd & (address == ADDR_DATA);
    do_pop     = pop_req & ~fifo_empty;
    push_req   = sample_valid & (state_q == ST_RUN);
    // A pop in the same cycle frees a slot, so a full FIFO only drops when not popping
    push_drop  = push_req & fifo_full & ~do_pop;
    flush      = cs_wr & (address == ADDR_CTRL) & writedata[3];
    do_push    = push_req & ~push_drop & ~flush;
  end

  // Assemble the STATUS register view from current state
  always_comb begin
    status_word              = '0;
    status_word[LVL_W-1:0]   = level_q;
    status_word[16]          = fifo_empty;
    status_word[17]          = fifo_full;
    status_word[18]          = overflow_q;
    status_word[19]          = underflow_q;
    status_word[25:24]       = state_q;
  end

  // Next-state logic for FIFO, registers, read data, interrupt and capture FSM
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    ctrl_d      = ctrl_q;
    thr_d       = thr_q;
    readdata_d  = readdata_q;
    irq_d       = ctrl_q[1] & ((level_q >= thr_q) | overflow_q);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end

    // Clears come first so a drop in the same cycle still leaves the flag set
    if (cs_wr && address == ADDR_STATUS && writedata[18]) overflow_d = 1'b0;
    if (push_drop) overflow_d = 1'b1;
    if (cs_wr && address == ADDR_STATUS && writedata[19]) underflow_d = 1'b0;
    if (pop_req && fifo_empty) underflow_d = 1'b1;

    if (cs_wr && address == ADDR_CTRL) ctrl_d = writedata[2:0];
    if (cs_wr && address == ADDR_THR) begin
      if (writedata > 32'(DEPTH)) thr_d = FULL_LVL;
      else                        thr_d = writedata[LVL_W-1:0];
    end

    if (cs_rd) begin
      case (address)
        ADDR_DATA:   readdata_d = do_pop ? 32'(mem_q[rd_ptr_q]) : 32'd0;
        ADDR_STATUS: readdata_d = status_word;
        ADDR_CTRL:   readdata_d = {29'd0, ctrl_q};
        default:     readdata_d = 32'(thr_q);
      endcase
    end

    case (state_q)
      ST_IDLE: if (ctrl_q[0]) state_d = ST_RUN;
      ST_RUN: begin
        if (!ctrl_q[0])                  state_d = ST_IDLE;
        else if (push_drop && ctrl_q[2]) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (!ctrl_q[0])       state_d = ST_IDLE;
        else if (!overflow_d) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      ctrl_q      <= '0;
      thr_q       <= THR_RST;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      ctrl_q      <= ctrl_d;
      thr_q       <= thr_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  // Sample storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= in_port;
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_audio_capture_ctrl.sv
// Testbench for the audio capture controller: directed scenarios plus a
// randomized phase, all checked against a queue-based reference model.
module tb_soc_system_audio_capture_ctrl;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_port = '0;
  logic        sample_valid = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  int          m_st;
  logic        m_ovf, m_unf, m_en, m_ie, m_stop;
  int          m_thr;
  logic        m_irq;
  logic [31:0] m_rdata;

  // Free-running clock
  always #5 clk = ~clk;

  soc_system_audio_capture_ctrl #(.DEPTH_LOG2(DL), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .in_port(in_port), .sample_valid(sample_valid),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic void modelReset();
    mq.delete();
    m_st = 0; m_ovf = 0; m_unf = 0; m_en = 0; m_ie = 0; m_stop = 0;
    m_thr = DEPTH / 2; m_irq = 0; m_rdata = '0;
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge
  function automatic void modelStep();
    logic        rd_en, wr_en, popping, pushing, dropped, flush, n_ovf, n_unf;
    logic [31:0] s;
    int          lvl;
    lvl   = mq.size();
    rd_en = chipselect && read;
    wr_en = chipselect && write;
    if (rd_en) begin
      case (address)
        2'd0: m_rdata = (lvl > 0) ? mq[0] : 32'd0;
        2'd1: begin
          s = 32'(lvl);
          s[16] = (lvl == 0);
          s[17] = (lvl == DEPTH);
          s[18] = m_ovf;
          s[19] = m_unf;
          s[25:24] = 2'(m_st);
          m_rdata = s;
        end
        2'd2: m_rdata = {29'd0, m_stop, m_ie, m_en};
        default: m_rdata = 32'(m_thr);
      endcase
    end
    m_irq   = m_ie && ((lvl >= m_thr) || m_ovf);
    popping = rd_en && address == 2'd0 && lvl > 0;
    pushing = sample_valid && m_st == 1;
    flush   = wr_en && address == 2'd2 && writedata[3];
    dropped = pushing && lvl == DEPTH && !popping;
    if (popping) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (pushing && !dropped) mq.push_back(in_port);
    n_ovf = m_ovf;
    n_unf = m_unf;
    if (wr_en && address == 2'd1 && writedata[18]) n_ovf = 0;
    if (dropped) n_ovf = 1;
    if (wr_en && address == 2'd1 && writedata[19]) n_unf = 0;
    if (rd_en && address == 2'd0 && lvl == 0) n_unf = 1;
    case (m_st)
      0: if (m_en) m_st = 1;
      1: if (!m_en) m_st = 0; else if (dropped && m_stop) m_st = 2;
      default: if (!m_en) m_st = 0; else if (!n_ovf) m_st = 1;
    endcase
    m_ovf = n_ovf;
    m_unf = n_unf;
    if (wr_en && address == 2'd2) begin
      m_en = writedata[0]; m_ie = writedata[1]; m_stop = writedata[2];
    end
    if (wr_en && address == 2'd3) m_thr = (writedata > 32'(DEPTH)) ? DEPTH : int'(writedata);
  endfunction

  // One clock: edge, model update, compare outputs, return bus to idle
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("readdata", readdata, m_rdata);
    checkOutput("irq", {31'd0, irq}, {31'd0, m_irq});
    sample_valid = 0; chipselect = 0; read = 0; write = 0;
  endtask

  task automatic wrReg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write = 1; address = a; writedata = d;
    applyStimulus();
  endtask

  task automatic rdReg(input logic [1:0] a);
    chipselect = 1; read = 1; address = a;
    applyStimulus();
  endtask

  task automatic pushSample(input logic [31:0] d);
    sample_valid = 1; in_port = d;
    applyStimulus();
  endtask

  task automatic pushRead(input logic [31:0] d);
    sample_valid = 1; in_port = d; chipselect = 1; read = 1; address = 2'd0;
    applyStimulus();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Asynchronous reset between edges; outputs must clear immediately
  task automatic doReset();
    reset = 1;
    #1;
    modelReset();
    checkOutput("rst_readdata", readdata, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  // Bound the total run time
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    checkOutput("init_readdata", readdata, 32'd0);
    checkOutput("init_irq", {31'd0, irq}, 32'd0);

    $display("[TB] capture and ordering");
    wrReg(2'd2, 32'h1);
    idleCycles(2);
    pushSample(32'h11112222);
    pushSample(32'h33334444);
    pushSample(32'h55556666);
    rdReg(2'd0); checkOutput("order0", readdata, 32'h11112222);
    rdReg(2'd0); checkOutput("order1", readdata, 32'h33334444);
    rdReg(2'd0); checkOutput("order2", readdata, 32'h55556666);
    rdReg(2'd0); checkOutput("empty_rd", readdata, 32'd0);
    rdReg(2'd1); checkOutput("ufl_bit", {31'd0, readdata[19]}, 32'd1);

    $display("[TB] reset mid-run");
    for (int i = 0; i < 5; i++) pushSample(32'hC0DE0000 + i);
    doReset();
    rdReg(2'd1); checkOutput("rst_status", readdata, 32'h00010000);
    rdReg(2'd3); checkOutput("rst_thr", readdata, 32'd8);

    $display("[TB] overflow and halt");
    doReset();
    wrReg(2'd2, 32'h5);
    idleCycles(2);
    for (int i = 0; i < 17; i++) pushSample(32'hA0000000 + i);
    rdReg(2'd1); checkOutput("ovf_status", readdata, 32'h02060010);
    for (int i = 0; i < 3; i++) pushSample(32'hB0000000 + i);
    rdReg(2'd1); checkOutput("halt_status", readdata, 32'h02060010);
    wrReg(2'd1, 32'h00040000);
    rdReg(2'd1); checkOutput("resume_status", readdata, 32'h01020010);
    pushSample(32'hDEADBEEF);
    rdReg(2'd1); checkOutput("reovf_status", readdata, 32'h02060010);
    rdReg(2'd0); checkOutput("ovf_head", readdata, 32'hA0000000);

    $display("[TB] threshold irq");
    doReset();
    wrReg(2'd2, 32'h3);
    wrReg(2'd3, 32'h4);
    idleCycles(1);
    for (int i = 0; i < 4; i++) pushSample(32'h10 + i);
    checkOutput("irq_lag", {31'd0, irq}, 32'd0);
    idleCycles(1);
    checkOutput("irq_rise", {31'd0, irq}, 32'd1);
    rdReg(2'd0);
    checkOutput("irq_hold", {31'd0, irq}, 32'd1);
    idleCycles(1);
    checkOutput("irq_fall", {31'd0, irq}, 32'd0);
    wrReg(2'd3, 32'h3F);
    rdReg(2'd3); checkOutput("thr_sat", readdata, 32'd16);

    $display("[TB] simultaneous push and pop");
    doReset();
    wrReg(2'd2, 32'h1);
    idleCycles(2);
    for (int i = 0; i < 16; i++) pushSample(32'h20000000 + i);
    pushRead(32'hABCD0001);
    checkOutput("pp_full_rd", readdata, 32'h20000000);
    rdReg(2'd1); checkOutput("pp_full_status", readdata, 32'h01020010);
    for (int i = 0; i < 16; i++) begin
      rdReg(2'd0);
      if (i == 15) checkOutput("pp_last", readdata, 32'hABCD0001);
    end
    pushRead(32'h00000077);
    checkOutput("pp_empty_rd", readdata, 32'd0);
    rdReg(2'd1); checkOutput("pp_empty_status", readdata, 32'h01080001);
    rdReg(2'd0); checkOutput("pp_empty_data", readdata, 32'h00000077);

    $display("[TB] wrap and flush");
    doReset();
    wrReg(2'd2, 32'h1);
    idleCycles(2);
    for (int i = 0; i < 40; i++) begin
      pushSample(32'h30000000 + i);
      rdReg(2'd0);
      checkOutput("wrap_data", readdata, 32'h30000000 + i);
    end
    for (int i = 0; i < 7; i++) pushSample(32'h40000000 + i);
    wrReg(2'd2, 32'h9);
    rdReg(2'd1); checkOutput("flush_status", readdata, 32'h01010000);
    rdReg(2'd2); checkOutput("flush_ctrl", readdata, 32'h1);

    $display("[TB] randomized traffic");
    doReset();
    wrReg(2'd2, 32'h3);
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      sample_valid = ($urandom_range(0, 1) == 1);
      in_port = $urandom;
      if (r < 35) begin
        chipselect = 1; read = 1;
        address = (r < 25) ? 2'd0 : 2'($urandom_range(1, 3));
      end else if (r < 50) begin
        chipselect = 1; write = 1;
        address = 2'($urandom_range(1, 3));
        case (address)
          2'd1: writedata = $urandom & 32'h000C0000;
          2'd2: writedata = {28'd0, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0)};
          default: writedata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
        endcase
      end else if (r < 55) begin
        chipselect = 0; read = 1; address = 2'd0;
      end
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
